mdio_master: RTL and testbench
==============================

# mdio_master

Command sequencer that sits directly upstream of the MDIO shift engine. It accepts single-register read/write commands from the host, arbitrates them against an autonomous PHY status poll, and drives the shift engine's start/op/address/data inputs. It captures read data and derives link state for the MAC.

## Interface
Parameters:
- PHYADDR, 5'd1, PHY address driven on every transaction
- STATUS_REG, 5'd1, register address read by the autonomous poll
- POLL_INTERVAL, 1000000, clocks between poll requests; minimum 2; fits in 24 bits

Ports:
- clk  in  1  single clock
- rst  in  1  reset, **synchronous, active-low**
- cmd_valid  in  1  host command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_reg  in  5  register address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse, host commands only
- rsp_rdata  out  16  read data; holds until the next host read completes
- poll_en  in  1  enables periodic status poll
- status_reg  out  16  last polled STATUS_REG value
- link_up  out  1  status_reg[2]
- link_change  out  1  one-cycle pulse when link_up toggles
- sh_phyaddr  out  5  to shift engine
- sh_regaddr  out  5  to shift engine
- sh_wdata  out  16  to shift engine
- sh_op  out  2  2'b01 write, 2'b10 read
- sh_start  out  1  one-cycle start pulse
- sh_ready  in  1  shift engine idle/done
- sh_rdata  in  16  shift engine read data; valid when sh_ready rises after a read

## Operation
- FSM states:
  - IDLE: while sh_ready=1, host command has priority over a pending poll. Accepting a host command latches cmd_* and records src=HOST. Otherwise, with poll_pend=1, the FSM loads regaddr=STATUS_REG, op=read, src=POLL. Either case goes to ISSUE.
  - ISSUE: sh_start=1 for exactly one cycle. If src=POLL, poll_pend is cleared here. Goes to WAIT_BUSY.
  - WAIT_BUSY: waits for sh_ready=0, then goes to WAIT_DONE.
  - WAIT_DONE: waits for sh_ready=1, captures sh_rdata on that edge, then goes to DONE.
  - DONE: one cycle.
    - HOST: rsp_valid=1. rsp_rdata is updated only for reads.
    - POLL: status_reg is updated. link_up is updated. link_change=1 if the new bit 2 differs from the old link_up.
    - Then returns to IDLE.
- cmd_ready = (state==IDLE) && sh_ready && rst. It is combinational and never depends on cmd_valid.
- sh_phyaddr, sh_regaddr, sh_wdata, sh_op are registered. They stay stable from ISSUE until the next load.
- Poll timer:
  - While poll_en=1, poll_cnt counts 0..POLL_INTERVAL-1 and wraps. At the wrap, poll_pend is set. Setting an already-set poll_pend has no further effect; polls never queue more than one deep.
  - poll_en=0 clears poll_cnt and poll_pend. A poll already past IDLE still completes and updates status.
- Poll timer set and ISSUE clear in the same cycle: set wins, so poll_pend remains 1.
- Host priority: a continuously valid host stream can starve polls. This is accepted behaviour.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=0 while rst=0
  - rsp_valid=0, rsp_rdata=0
  - status_reg=0, link_up=0, link_change=0
  - sh_start=0, sh_op=0, sh_regaddr=0, sh_wdata=0, sh_phyaddr=PHYADDR
  - poll_cnt=0, poll_pend=0
- Reset mid-transaction: all of the above apply on the next edge. No rsp_valid is issued for the aborted command. The shift engine is reset alongside.
- Accept at edge N → sh_start high during cycle N+1.
- If the shift engine raises sh_ready at edge D, rsp_valid/link_change are high during cycle D+1. The next accept is possible at D+2 at the earliest.
- First poll_pend after poll_en rises occurs POLL_INTERVAL cycles later.
- rsp_valid and link_change are never high for more than one consecutive cycle.
- Only one transaction is outstanding at a time.

## Test plan
- **Host read.** Reset, poll_en=0. Shift model busy 10 cycles, returns 16'h796D. Issue cmd read reg 2 → sh_op=2'b10, sh_regaddr=2, one sh_start pulse; rsp_valid one cycle after sh_ready rises, rsp_rdata=16'h796D.
- **Host write.** cmd write reg 0, wdata 16'h1140 → sh_op=2'b01, sh_wdata=16'h1140; rsp_valid pulse; rsp_rdata unchanged.
- **Poll and link change.** POLL_INTERVAL=50, poll_en=1, model returns 16'h0004 then 16'h0000.
  - First poll: sh_start at cycle ~51 with regaddr=1; link_up=1, link_change pulse.
  - Second poll: link_up=0, second link_change pulse.
  - Polls with unchanged data produce no pulse.
- **Priority collision.** poll_pend set and cmd_valid asserted in the same IDLE cycle → host command issued first, poll issued immediately after; no rsp_valid for the poll.
- **Reset mid-operation.** Drop rst during WAIT_DONE → next cycle: all outputs at reset values, no rsp_valid. After rst release with sh_ready=1, cmd_ready=1.
- **poll_en deassert.** Deassert poll_en while poll_pend=1 and idle-blocked by a host command → no poll issued; poll_cnt restarts from 0 on re-enable.

Source files
------------

// File: rtl/mdio_master.sv
// ============================================================================
// mdio_master : host/poll command sequencer in front of the MDIO shift engine
// Rev 1.0
// ============================================================================
`default_nettype none

module mdio_master #(
    parameter logic [4:0]  PHYADDR       = 5'd1,
    parameter logic [4:0]  STATUS_REG    = 5'd1,
    parameter int unsigned POLL_INTERVAL = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic        poll_en,
    output logic [15:0] status_reg,
    output logic        link_up,
    output logic        link_change,
    output logic [4:0]  sh_phyaddr,
    output logic [4:0]  sh_regaddr,
    output logic [15:0] sh_wdata,
    output logic [1:0]  sh_op,
    output logic        sh_start,
    input  logic        sh_ready,
    input  logic [15:0] sh_rdata
);

    localparam logic [1:0]  OP_WRITE  = 2'b01;
    localparam logic [1:0]  OP_READ   = 2'b10;
    localparam logic [23:0] POLL_LAST = 24'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        src_poll_q, src_poll_d;
    logic [4:0]  phyaddr_q;
    logic [4:0]  regaddr_q, regaddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  op_q, op_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] status_q, status_d;
    logic        link_up_q, link_up_d;
    logic        link_change_q, link_change_d;
    logic [23:0] poll_cnt_q, poll_cnt_d;
    logic        poll_pend_q, poll_pend_d;

    logic        w_accept;
    logic        w_done;
    logic        w_wrap;

    assign cmd_ready = (state_q == S_IDLE) && sh_ready && rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (state_q == S_WAIT_DONE) && sh_ready;
    assign w_wrap    = poll_en && (poll_cnt_q == POLL_LAST);

    always_comb begin
        state_d    = state_q;
        src_poll_d = src_poll_q;
        regaddr_d  = regaddr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    src_poll_d = 1'b0;
                    regaddr_d  = cmd_reg;
                    wdata_d    = cmd_wdata;
                    op_d       = cmd_write ? OP_WRITE : OP_READ;
                    state_d    = S_ISSUE;
                end else if (sh_ready && poll_pend_q) begin
                    src_poll_d = 1'b1;
                    regaddr_d  = STATUS_REG;
                    op_d       = OP_READ;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!sh_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (sh_ready) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Completion outputs are registered on the capture edge so they are all valid during DONE.
    always_comb begin
        rsp_valid_d   = w_done && !src_poll_q;
        rsp_rdata_d   = (w_done && !src_poll_q && (op_q == OP_READ)) ? sh_rdata : rsp_rdata_q;
        status_d      = (w_done && src_poll_q) ? sh_rdata : status_q;
        link_up_d     = (w_done && src_poll_q) ? sh_rdata[2] : link_up_q;
        link_change_d = w_done && src_poll_q && (sh_rdata[2] != link_up_q);
    end

    // A timer wrap in the same cycle as the poll issue keeps the pending flag set.
    always_comb begin
        poll_cnt_d  = poll_cnt_q + 24'd1;
        poll_pend_d = poll_pend_q;
        if (!poll_en) begin
            poll_cnt_d  = 24'd0;
            poll_pend_d = 1'b0;
        end else if (w_wrap) begin
            poll_cnt_d  = 24'd0;
            poll_pend_d = 1'b1;
        end else if ((state_q == S_ISSUE) && src_poll_q) begin
            poll_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            src_poll_q    <= 1'b0;
            phyaddr_q     <= PHYADDR;
            regaddr_q     <= 5'd0;
            wdata_q       <= 16'd0;
            op_q          <= 2'b00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 16'd0;
            status_q      <= 16'd0;
            link_up_q     <= 1'b0;
            link_change_q <= 1'b0;
            poll_cnt_q    <= 24'd0;
            poll_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_poll_q    <= src_poll_d;
            phyaddr_q     <= PHYADDR;
            regaddr_q     <= regaddr_d;
            wdata_q       <= wdata_d;
            op_q          <= op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            status_q      <= status_d;
            link_up_q     <= link_up_d;
            link_change_q <= link_change_d;
            poll_cnt_q    <= poll_cnt_d;
            poll_pend_q   <= poll_pend_d;
        end
    end

    assign sh_start    = (state_q == S_ISSUE);
    assign sh_phyaddr  = phyaddr_q;
    assign sh_regaddr  = regaddr_q;
    assign sh_wdata    = wdata_q;
    assign sh_op       = op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign status_reg  = status_q;
    assign link_up     = link_up_q;
    assign link_change = link_change_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_master.sv
// ============================================================================
// tb_mdio_master : directed bench for mdio_master with a behavioural shift engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdio_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_reg = 5'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        poll_en = 1'b0;
    logic [15:0] status_reg;
    logic        link_up;
    logic        link_change;
    logic [4:0]  sh_phyaddr;
    logic [4:0]  sh_regaddr;
    logic [15:0] sh_wdata;
    logic [1:0]  sh_op;
    logic        sh_start;
    logic        sh_ready = 1'b1;
    logic [15:0] sh_rdata = 16'd0;

    mdio_master #(
        .PHYADDR       (5'd1),
        .STATUS_REG    (5'd1),
        .POLL_INTERVAL (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_reg     (cmd_reg),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .poll_en     (poll_en),
        .status_reg  (status_reg),
        .link_up     (link_up),
        .link_change (link_change),
        .sh_phyaddr  (sh_phyaddr),
        .sh_regaddr  (sh_regaddr),
        .sh_wdata    (sh_wdata),
        .sh_op       (sh_op),
        .sh_start    (sh_start),
        .sh_ready    (sh_ready),
        .sh_rdata    (sh_rdata)
    );

    always #5 clk = ~clk;

    // Shift engine model: busy 10 cycles after a start, then returns m_resp.
    logic [15:0] m_resp = 16'd0;
    int          m_cnt = 0;
    int          n_start = 0;
    always @(posedge clk) begin
        if (!rst) begin
            sh_ready <= 1'b1;
            m_cnt    <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                sh_ready <= 1'b1;
                sh_rdata <= m_resp;
            end
        end else if (sh_start) begin
            sh_ready <= 1'b0;
            m_cnt    <= 10;
            n_start  <= n_start + 1;
        end
    end

    int  rsp_cnt = 0;
    int  lc_cnt = 0;
    int  dbl_cnt = 0;
    logic prev_rsp = 1'b0;
    logic prev_lc = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (link_change) lc_cnt <= lc_cnt + 1;
        if ((rsp_valid && prev_rsp) || (link_change && prev_lc)) dbl_cnt <= dbl_cnt + 1;
        prev_rsp <= rsp_valid;
        prev_lc  <= link_change;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return sh_start;
            1:       return rsp_valid;
            2:       return link_change;
            default: return cmd_ready;
        endcase
    endfunction

    task automatic wait_for(input int which, input int lim, input string nm, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (sel(which) === 1'b1) break;
            if (n >= lim) begin
                chk(nm, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic host_cmd(input logic w, input logic [4:0] r, input logic [15:0] d);
        int n;
        if (cmd_ready !== 1'b1) wait_for(3, 200, "cmd_ready_timeout", n);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_reg   = r;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  r;
        logic [15:0] d;
        logic [15:0] resp;
        logic [1:0]  eop;
        logic [15:0] erd;
    } vec_t;

    vec_t vt[5];

    initial begin
        int n, s0, snap, lcs;
        vt[0] = '{1'b0, 5'd2,  16'h0000, 16'h796D, 2'b10, 16'h796D};
        vt[1] = '{1'b1, 5'd0,  16'h1140, 16'hBEEF, 2'b01, 16'h796D};
        vt[2] = '{1'b0, 5'd3,  16'h0000, 16'hA5A5, 2'b10, 16'hA5A5};
        vt[3] = '{1'b1, 5'd31, 16'hFFFF, 16'h1234, 2'b01, 16'hA5A5};
        vt[4] = '{1'b0, 5'd16, 16'h5A5A, 16'h0000, 2'b10, 16'h0000};

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_status", status_reg, 0);
        chk("rst_link_up", link_up, 0);
        chk("rst_link_change", link_change, 0);
        chk("rst_sh_start", sh_start, 0);
        chk("rst_sh_op", sh_op, 0);
        chk("rst_sh_regaddr", sh_regaddr, 0);
        chk("rst_sh_wdata", sh_wdata, 0);
        chk("rst_sh_phyaddr", sh_phyaddr, 5'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 5; i++) begin
            m_resp = vt[i].resp;
            s0 = n_start;
            host_cmd(vt[i].w, vt[i].r, vt[i].d);
            chk("host_sh_start", sh_start, 1);
            chk("host_sh_op", sh_op, vt[i].eop);
            chk("host_sh_regaddr", sh_regaddr, vt[i].r);
            chk("host_sh_wdata", sh_wdata, vt[i].d);
            chk("host_sh_phyaddr", sh_phyaddr, 5'd1);
            @(negedge clk);
            chk("host_start_one_cycle", sh_start, 0);
            wait_for(1, 100, "host_rsp_timeout", n);
            chk("host_rsp_rdata", rsp_rdata, vt[i].erd);
            @(negedge clk);
            chk("host_rsp_one_cycle", rsp_valid, 0);
            chk("host_one_start", n_start - s0, 1);
        end
        chk("host_rsp_count", rsp_cnt, 5);
        chk("host_no_status", status_reg, 0);

        // Periodic poll: link goes up, then down, then stays down.
        snap = rsp_cnt;
        m_resp = 16'h0004;
        poll_en = 1'b1;
        wait_for(0, 200, "poll1_timeout", n);
        chk("poll1_cycle", n, 51);
        chk("poll1_regaddr", sh_regaddr, 5'd1);
        chk("poll1_op", sh_op, 2'b10);
        wait_for(2, 100, "lc1_timeout", n);
        chk("lc1_link_up", link_up, 1);
        chk("lc1_status", status_reg, 16'h0004);
        m_resp = 16'h0000;
        wait_for(2, 200, "lc2_timeout", n);
        chk("lc2_link_up", link_up, 0);
        chk("lc2_status", status_reg, 16'h0000);
        @(negedge clk);
        lcs = lc_cnt;
        s0 = n_start;
        repeat (120) @(negedge clk);
        chk("poll_repeats", (n_start - s0) >= 2, 1);
        chk("poll_no_change_pulse", lc_cnt, lcs);
        chk("poll_no_rsp", rsp_cnt, snap);

        // Host and poll pending together: host first, poll right after.
        poll_en = 1'b0;
        wait_for(3, 200, "coll_idle_timeout", n);
        poll_en = 1'b1;
        repeat (50) @(negedge clk);
        m_resp = 16'h1234;
        host_cmd(1'b0, 5'd5, 16'h0000);
        chk("coll_host_start", sh_start, 1);
        chk("coll_host_regaddr", sh_regaddr, 5'd5);
        wait_for(1, 100, "coll_rsp_timeout", n);
        chk("coll_rsp_rdata", rsp_rdata, 16'h1234);
        m_resp = 16'h0004;
        wait_for(0, 10, "coll_poll_timeout", n);
        chk("coll_poll_gap", n, 2);
        chk("coll_poll_regaddr", sh_regaddr, 5'd1);
        chk("coll_poll_op", sh_op, 2'b10);
        snap = rsp_cnt;
        wait_for(2, 50, "coll_lc_timeout", n);
        chk("coll_link_up", link_up, 1);
        chk("coll_status", status_reg, 16'h0004);
        repeat (3) @(negedge clk);
        chk("coll_poll_no_rsp", rsp_cnt, snap);
        poll_en = 1'b0;
        wait_for(3, 200, "midop_idle_timeout", n);

        // Reset during WAIT_DONE.
        m_resp = 16'hCAFE;
        host_cmd(1'b0, 5'd7, 16'h0000);
        chk("midop_start", sh_start, 1);
        repeat (4) @(negedge clk);
        chk("midop_busy", sh_ready, 0);
        snap = rsp_cnt;
        rst = 1'b0;
        @(negedge clk);
        chk("midop_cmd_ready", cmd_ready, 0);
        chk("midop_rsp_valid", rsp_valid, 0);
        chk("midop_rsp_rdata", rsp_rdata, 0);
        chk("midop_status", status_reg, 0);
        chk("midop_link_up", link_up, 0);
        chk("midop_sh_start", sh_start, 0);
        chk("midop_sh_op", sh_op, 0);
        chk("midop_sh_regaddr", sh_regaddr, 0);
        chk("midop_sh_phyaddr", sh_phyaddr, 5'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_release_ready", cmd_ready, 1);
        repeat (20) @(negedge clk);
        chk("midop_no_rsp", rsp_cnt, snap);

        // poll_en drop while a poll is pending behind a host command.
        poll_en = 1'b1;
        s0 = n_start;
        repeat (44) @(negedge clk);
        host_cmd(1'b1, 5'd9, 16'h00AA);
        chk("pdis_host_start", sh_start, 1);
        repeat (7) @(negedge clk);
        poll_en = 1'b0;
        repeat (60) @(negedge clk);
        chk("pdis_no_poll", n_start - s0, 1);
        poll_en = 1'b1;
        wait_for(0, 200, "reen_timeout", n);
        chk("reen_poll_cycle", n, 51);
        chk("reen_regaddr", sh_regaddr, 5'd1);
        poll_en = 1'b0;
        repeat (20) @(negedge clk);

        chk("pulse_single_cycle", dbl_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
